// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 scancode decoder tracking NUM_KEYS keys with press/release/repeat pulses and Pause detection
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   rx_data      received scancode byte
//   rx_valid     one-cycle strobe, rx_data valid
//   held         level per key, key currently down
//   press        one-cycle pulse on make of a key not already held
//   key_release  one-cycle pulse on break of a held key
//   key_repeat   one-cycle typematic pulse for the last-pressed key
//   any_held     OR of held
//   pause        one-cycle pulse after a complete E1 (Pause) sequence
//   seq_err      one-cycle pulse on multi-byte sequence timeout
module ps2_key_decoder #(
  parameter int NUM_KEYS = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES = {9'h174, 9'h16B, 9'h172, 9'h175},
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                any_held,
  output logic                pause,
  output logic                seq_err
);
  localparam int KW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam int RD = REPEAT_DELAY > 0 ? REPEAT_DELAY - 1 : 0;
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;
  state_t              state;
  logic [2:0]          skip;
  logic [TW-1:0]       tcnt;
  logic [RW-1:0]       rcnt;
  logic                rphase;
  logic [KW-1:0]       last_key;
  logic                last_ok;
  logic [8:0]          code;
  logic [NUM_KEYS-1:0] match, new_press, new_rel, held_n;
  logic [KW-1:0]       hi;
  logic                ign, is_make, is_brk, rpt_on, rpt_hit;
  always_comb begin
    code = {state == EXT || state == EXT_BRK, rx_data};
    match = '0;
    hi = '0;
    for (int i = 0; i < NUM_KEYS; i++) match[i] = KEY_CODES[9*i +: 9] == code;
    ign = rx_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    is_make = rx_valid && (state == IDLE ? !ign && !(rx_data inside {8'hE0, 8'hF0, 8'hE1})
                                         : state == EXT && !(rx_data inside {8'hE0, 8'hF0}));
    is_brk = rx_valid && (state == BRK || state == EXT_BRK);
    new_press = is_make ? match & ~held : '0;
    new_rel = is_brk ? match & held : '0;
    held_n = (held | new_press) & ~new_rel;
    // later iterations overwrite, so the highest newly pressed index wins
    for (int i = 0; i < NUM_KEYS; i++) if (new_press[i]) hi = KW'(i);
    rpt_on = last_ok && held[last_key] && REPEAT_DELAY != 0;
    rpt_hit = rpt_on && rcnt == (rphase ? RW'(REPEAT_PERIOD - 1) : RW'(RD));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      skip <= '0;
      tcnt <= '0;
      rcnt <= '0;
      rphase <= 1'b0;
      last_key <= '0;
      last_ok <= 1'b0;
      held <= '0;
      press <= '0;
      key_release <= '0;
      key_repeat <= '0;
      any_held <= 1'b0;
      pause <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      held <= held_n;
      press <= new_press;
      key_release <= new_rel;
      any_held <= |held_n;
      pause <= 1'b0;
      seq_err <= 1'b0;
      key_repeat <= '0;
      // an arriving byte always beats a timeout on the same cycle
      if (rx_valid) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            state <= rx_data == 8'hE0 ? EXT : rx_data == 8'hF0 ? BRK : rx_data == 8'hE1 ? SKIP : IDLE;
            if (rx_data == 8'hE1) skip <= 3'd7;
          end
          EXT: state <= rx_data == 8'hF0 ? EXT_BRK : rx_data == 8'hE0 ? EXT : IDLE;
          SKIP: begin
            skip <= skip - 1'b1;
            if (skip == 3'd1) begin
              state <= IDLE;
              pause <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state <= IDLE;
          seq_err <= 1'b1;
          tcnt <= '0;
          skip <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
      // rphase=0 counts the initial delay, rphase=1 the repeat period
      if (|new_press) begin
        last_key <= hi;
        last_ok <= 1'b1;
        rcnt <= '0;
        rphase <= 1'b0;
      end else if (last_ok && new_rel[last_key]) begin
        last_ok <= 1'b0;
        rcnt <= '0;
        rphase <= 1'b0;
      end else if (rpt_hit) begin
        key_repeat <= NUM_KEYS'(1) << last_key;
        rcnt <= '0;
        rphase <= 1'b1;
      end else if (rpt_on && rcnt != '1) begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed table-driven bench for ps2_key_decoder with short timeout/repeat settings
module tb_ps2_key_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [3:0] held, press, key_release, key_repeat;
  logic       any_held, pause, seq_err;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] d;
    logic [3:0] h;
    logic [3:0] p;
    logic [3:0] r;
    logic       a;
    logic       z;
  } vec_t;
  vec_t tv[45];
  int n0, n3, f3, np, fp, bad;
  int t[3];

  ps2_key_decoder #(
    .NUM_KEYS(4),
    .TIMEOUT_CYCLES(50),
    .REPEAT_DELAY(100),
    .REPEAT_PERIOD(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .held(held),
    .press(press),
    .key_release(key_release),
    .key_repeat(key_repeat),
    .any_held(any_held),
    .pause(pause),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", n, i, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic all_zero(input string n);
    chk({n, "_held"}, 0, held, 0);
    chk({n, "_press"}, 0, press, 0);
    chk({n, "_rel"}, 0, key_release, 0);
    chk({n, "_rpt"}, 0, key_repeat, 0);
    chk({n, "_any"}, 0, any_held, 0);
    chk({n, "_pause"}, 0, pause, 0);
    chk({n, "_err"}, 0, seq_err, 0);
  endtask

  initial begin
    tv = '{
      '{8'hE0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'h75, 4'h1, 4'h1, 4'h0, 1'b1, 1'b0},
      '{8'hE0, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'hF0, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'h75, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0},
      '{8'h75, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'h6B, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'hAA, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'h72, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'hE0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'h75, 4'h1, 4'h1, 4'h0, 1'b1, 1'b0},
      '{8'hE0, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'h75, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'hE0, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'h75, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'hE0, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'h74, 4'h9, 4'h8, 4'h0, 1'b1, 1'b0},
      '{8'hE0, 4'h9, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'hF0, 4'h9, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'h74, 4'h1, 4'h0, 4'h8, 1'b1, 1'b0},
      '{8'hE0, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'hF0, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'h75, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0},
      '{8'hE0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'hF0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'h75, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'hE1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'h14, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'h77, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'hE1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'hF0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'h14, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'hF0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'h77, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1},
      '{8'hE0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0},
      '{8'h72, 4'h2, 4'h2, 4'h0, 1'b1, 1'b0},
      '{8'hE0, 4'h2, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'hE0, 4'h2, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'h6B, 4'h6, 4'h4, 4'h0, 1'b1, 1'b0},
      '{8'hE0, 4'h6, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'hF0, 4'h6, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'h72, 4'h4, 4'h0, 4'h2, 1'b1, 1'b0},
      '{8'hE0, 4'h4, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'hF0, 4'h4, 4'h0, 4'h0, 1'b1, 1'b0},
      '{8'h6B, 4'h0, 4'h0, 4'h4, 1'b0, 1'b0}
    };
    repeat (3) @(negedge clk);
    all_zero("reset");
    reset = 1'b0;
    for (int i = 0; i < 45; i++) begin
      send(tv[i].d);
      chk("held", i, held, tv[i].h);
      chk("press", i, press, tv[i].p);
      chk("release", i, key_release, tv[i].r);
      chk("any_held", i, any_held, tv[i].a);
      chk("pause", i, pause, tv[i].z);
      chk("repeat", i, key_repeat, 0);
      chk("seq_err", i, seq_err, 0);
    end
    // typematic repeat on up: pulses expected 100, 120, 140 cycles after the press
    send(8'hE0);
    send(8'h75);
    chk("rpt_press", 0, press, 4'h1);
    np = 0;
    bad = 0;
    t = '{0, 0, 0};
    for (int k = 1; k <= 145; k++) begin
      @(negedge clk);
      if (key_repeat[0]) begin
        if (np < 3) t[np] = k;
        np++;
      end
      if (key_repeat[3:1] != 0) bad++;
    end
    chk("rpt_count", 0, np, 3);
    chk("rpt_t0", 0, t[0], 100);
    chk("rpt_t1", 0, t[1], 120);
    chk("rpt_t2", 0, t[2], 140);
    chk("rpt_other", 0, bad, 0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("rpt_rel", 0, key_release, 4'h1);
    np = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (key_repeat != 0) np++;
    end
    chk("rpt_after_rel", 0, np, 0);
    // press up then right: only the right key repeats
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'h74);
    chk("retarget_held", 0, held, 4'h9);
    n0 = 0;
    n3 = 0;
    f3 = 0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (key_repeat[0]) n0++;
      if (key_repeat[3]) begin
        if (n3 == 0) f3 = k;
        n3++;
      end
    end
    chk("retarget_bit0", 0, n0, 0);
    chk("retarget_first3", 0, f3, 100);
    chk("retarget_count3", 0, n3, 2);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    chk("retarget_clear", 0, held, 4'h0);
    // timeout after a lone E0
    send(8'hE0);
    np = 0;
    fp = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (seq_err) begin
        if (np == 0) fp = k;
        np++;
      end
    end
    chk("timeout_first", 0, fp, 50);
    chk("timeout_count", 0, np, 1);
    send(8'h75);
    chk("after_to_held", 0, held, 4'h0);
    chk("after_to_press", 0, press, 4'h0);
    np = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (seq_err) np++;
    end
    chk("idle_no_timeout", 0, np, 0);
    // byte lands on the cycle the timeout would fire
    send(8'hE0);
    repeat (48) @(negedge clk);
    send(8'h75);
    chk("race_press", 0, press, 4'h1);
    chk("race_err", 0, seq_err, 0);
    np = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (seq_err) np++;
    end
    chk("race_no_err", 0, np, 0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("race_rel", 0, key_release, 4'h1);
    // asynchronous reset in the middle of a break sequence
    send(8'hE0);
    send(8'h75);
    send(8'hF0);
    chk("pre_reset_held", 0, held, 4'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    send(8'hE0);
    send(8'h75);
    chk("post_reset_held", 0, held, 4'h1);
    chk("post_reset_press", 0, press, 4'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Parametrised PS/2 set-2 scancode decoder and the successor to the fixed four-arrow key detector.
- Consumes the byte stream from the PS/2 receiver and tracks held state for NUM_KEYS programmable keys, including E0-extended codes.
- Emits per-key press/release pulses and typematic repeat pulses, and recognises the Pause (E1) sequence.
- Sits between the PS/2 receiver and the game-logic input registers.

Parameters:
- NUM_KEYS, 4, number of tracked keys (1..16).
- KEY_CODES, {9'h174,9'h16B,9'h172,9'h175}, packed 9 bits per key. Key i is at [9i+8:9i]. Bit 8 = E0-extended, bits 7:0 = make code. Default order: key0 up, key1 down, key2 left, key3 right.
- TIMEOUT_CYCLES, 2_000_000, idle cycles allowed inside a multi-byte sequence before abort (20 ms at 100 MHz).
- REPEAT_DELAY, 50_000_000, cycles from press to first repeat pulse. 0 disables repeat.
- REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat pulses (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received scancode byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid.
- held  out  NUM_KEYS  level; key i currently down.
- press  out  NUM_KEYS  one-cycle pulse on make of a key not already held.
- release  out  NUM_KEYS  one-cycle pulse on break of a held key.
- repeat  out  NUM_KEYS  one-cycle typematic pulse for the last-pressed key.
- any_held  out  1  OR of held.
- pause  out  1  one-cycle pulse when a complete E1 sequence has been consumed.
- seq_err  out  1  one-cycle pulse on sequence timeout.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0, last_key invalid.
- All outputs are registered. A byte accepted at edge t (rx_valid high) is reflected in held/press/release/pause at t+1.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
- IDLE transitions:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> SKIP, skip counter = 7.
  - AA, FA, FE, EE, 00, FF are ignored and the state stays IDLE.
  - Any other byte c is a make of {0,c}.
- EXT: F0 -> EXT_BRK; E0 -> stay in EXT; any other c is a make of {1,c}, then IDLE.
- BRK: byte c is a break of {0,c}, then IDLE.
- EXT_BRK: byte c is a break of {1,c}, then IDLE.
- SKIP: each byte decrements the skip counter. When the count reaches 0 the FSM returns to IDLE and pause pulses. Bytes consumed in SKIP are never decoded.
- Make {x,c}:
  - Every key i with KEY_CODES[i]=={x,c} is matched.
  - If held[i]=0: held[i]<=1, press[i] pulses, last_key<=i, repeat counter cleared.
  - If already held (device typematic), no press and no held change.
  - Duplicate KEY_CODES entries all update together. last_key takes the highest matching index.
- Break {x,c}: for each matching key with held[i]=1, held[i]<=0 and release[i] pulses. A break of an unheld key is silent.
- Unmatched codes only advance the FSM.
- Timeout:
  - A counter runs in every non-IDLE state and is cleared on each rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 the FSM goes to IDLE and seq_err pulses.
  - If rx_valid arrives on the same cycle, the byte wins and no error is raised.
- Repeat:
  - Runs only while last_key is valid, held[last_key]=1 and REPEAT_DELAY!=0.
  - First pulse comes REPEAT_DELAY cycles after the press pulse; later pulses come every REPEAT_PERIOD cycles.
  - A new press of another key retargets last_key and restarts the delay.
  - Releasing last_key invalidates it and stops repeat. Other keys that are still held do not repeat.
- Counter widths are $clog2(max value + 1). Repeat counters saturate and never wrap.
- Reset asserted mid-sequence clears everything. The next byte after reset is decoded from IDLE.

Test Plan:
- Default params: bytes E0,75 -> held=4'b0001 and press[0] one pulse at t+1. Then E0,F0,75 -> held=0 and release[0] pulse.
- Bytes 75 (no E0, keypad 8) -> no held/press change and FSM back in IDLE. Then 6B -> no match.
- E0,75 sent three times -> exactly one press[0]. Then E0,74 -> held=4'b1001 and any_held=1.
- REPEAT_DELAY=100, REPEAT_PERIOD=20: press up -> repeat[0] at +100, +120, +140 cycles. Release -> no further pulses. Press up then right -> repeat only on bit 3.
- E1,14,77,E1,F0,14,F0,77 -> one pause pulse after the 8th byte and no held change. Then E0,72 -> held[1]=1.
- TIMEOUT_CYCLES=50: E0, then silence -> seq_err at 50 cycles and FSM IDLE. Then 75 -> no match (not treated as extended). Also assert reset after F0 -> all outputs 0, and a following E0,75 decodes normally.
